// File: rtl/fft_stream_pkg.sv
// Shared definitions for the FFT peripheral stream path.
// Contents: stream data width, default sink geometry and the stream word type.
package fft_stream_pkg;

   localparam int unsigned FFT_DATA_W        = 32;
   localparam int unsigned FFT_DEF_DEPTH     = 16;
   localparam int unsigned FFT_DEF_SKID      = 2;
   localparam int unsigned FFT_DEF_FRAME_LEN = 64;

   typedef logic [FFT_DATA_W-1:0] fft_word_t;

endpackage

// File: rtl/fft_sink_fifo.sv
// Synchronous FIFO behind the FFT stream sink.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   push_i, wdata_i write request and word (request may be refused when full)
//   pop_i           pop request (ignored when empty)
//   push_ok_o       the write request is accepted this cycle
//   level_o         registered occupancy; level_next_o is the value after this edge
//   rd_data_o       popped word, registered; rd_valid_o marks it for one cycle
// A pop and a push in the same cycle at full both happen, so the push is accepted.
// A pop at empty is ignored even if a push arrives in the same cycle.
module fft_sink_fifo
   import fft_stream_pkg::*;
#(
   parameter int unsigned DEPTH = FFT_DEF_DEPTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   push_i,
   input  fft_word_t              wdata_i,
   input  logic                   pop_i,
   output logic                   push_ok_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic [$clog2(DEPTH):0] level_next_o,
   output fft_word_t              rd_data_o,
   output logic                   rd_valid_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   fft_word_t         mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]     level_q, level_d;
   fft_word_t         rd_data_q;
   logic              rd_valid_q;
   logic              pop_ok, push_ok;

   always_comb begin
      pop_ok  = pop_i && (level_q != '0);
      push_ok = push_i && ((level_q != LW'(DEPTH)) || pop_ok);
      level_d = level_q;
      if (push_ok && !pop_ok) begin
         level_d = level_q + LW'(1);
      end else if (pop_ok && !push_ok) begin
         level_d = level_q - LW'(1);
      end
   end

   // Storage is not reset; pointers and level define which entries are live.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            // At full with a simultaneous push this reads the old head before it is overwritten.
            rd_data_q <= mem_q[rd_ptr_q];
            rd_ptr_q  <= rd_ptr_q + AW'(1);
         end
         rd_valid_q <= pop_ok;
         level_q    <= level_d;
      end
   end

   assign push_ok_o    = push_ok;
   assign level_o      = level_q;
   assign level_next_o = level_d;
   assign rd_data_o    = rd_data_q;
   assign rd_valid_o   = rd_valid_q;

endmodule

// File: rtl/fft_stream_sink.sv
// Receiving end of the FFT 32-bit valid/ready sample stream.
// Buffers words in fft_sink_fifo, drives registered back-pressure with SKID entries of slack,
// flags dropped words, and delimits frames of FRAME_LEN write attempts.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_data, i_data_valid  stream input; every valid cycle is a write attempt
//   o_data_ready          registered back-pressure
//   i_rd_en               pop request; o_rd_data/o_rd_valid one cycle later
//   o_level, o_empty, o_full  occupancy
//   o_overflow, i_clr_ovf sticky drop flag and its clear
//   o_frame_done, o_frame_cnt  frame-end pulse and completed-frame count
// Build option: FFT_SINK_DROP_CNT_EN adds o_drop_cnt, a saturating count of dropped words.
module fft_stream_sink
   import fft_stream_pkg::*;
#(
   parameter int unsigned DEPTH     = FFT_DEF_DEPTH,
   parameter int unsigned SKID      = FFT_DEF_SKID,
   parameter int unsigned FRAME_LEN = FFT_DEF_FRAME_LEN
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  fft_word_t              i_data,
   input  logic                   i_data_valid,
   output logic                   o_data_ready,
   input  logic                   i_rd_en,
   output fft_word_t              o_rd_data,
   output logic                   o_rd_valid,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_empty,
   output logic                   o_full,
   output logic                   o_overflow,
   input  logic                   i_clr_ovf,
`ifdef FFT_SINK_DROP_CNT_EN
   output logic [15:0]            o_drop_cnt,
`endif
   output logic                   o_frame_done,
   output logic [15:0]            o_frame_cnt
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam int unsigned CW = $clog2(FRAME_LEN);

   logic [LW-1:0] level, level_next;
   logic          push_ok, drop;
   logic          ready_q, ready_d;
   logic          ovf_q, ovf_d;
   logic [CW-1:0] sample_cnt_q, sample_cnt_d;
   logic          frame_done_q, frame_done_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;

   fft_sink_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .push_i       (i_data_valid),
      .wdata_i      (i_data),
      .pop_i        (i_rd_en),
      .push_ok_o    (push_ok),
      .level_o      (level),
      .level_next_o (level_next),
      .rd_data_o    (o_rd_data),
      .rd_valid_o   (o_rd_valid)
   );

   always_comb begin
      drop         = i_data_valid && !push_ok;
      // Keep SKID entries free so words in flight after ready falls still fit.
      ready_d      = (LW'(DEPTH) - level_next) > LW'(SKID);
      ovf_d        = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (i_clr_ovf) begin
         ovf_d = 1'b0;
      end
      sample_cnt_d = sample_cnt_q;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      if (i_data_valid) begin
         if (sample_cnt_q == CW'(FRAME_LEN - 1)) begin
            sample_cnt_d = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
         end else begin
            sample_cnt_d = sample_cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ready_q      <= 1'b0;
         ovf_q        <= 1'b0;
         sample_cnt_q <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         ready_q      <= ready_d;
         ovf_q        <= ovf_d;
         sample_cnt_q <= sample_cnt_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

`ifdef FFT_SINK_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         // A clear coinciding with a drop restarts the count at this drop.
         if (i_clr_ovf) begin
            drop_cnt_d = 16'd1;
         end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end else if (i_clr_ovf) begin
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign o_drop_cnt = drop_cnt_q;
`endif

   assign o_data_ready = ready_q;
   assign o_level      = level;
   assign o_empty      = (level == '0);
   assign o_full       = (level == LW'(DEPTH));
   assign o_overflow   = ovf_q;
   assign o_frame_done = frame_done_q;
   assign o_frame_cnt  = frame_cnt_q;

endmodule
